// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Single-cycle ops finish in one cycle; shifts
// iterate one bit per cycle through an accumulator, so no barrel shifter.
//
// Handshake: an op is taken on a rising edge where in_valid && in_ready
// (in_ready is high only in IDLE). A result is offered while out_valid is
// high (DONE only); dout/err hold steady until a rising edge sees out_ready.
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_shifted;
  logic [SHAMT_W-1:0] cnt;
  logic               shift_left;
  logic               fill_bit;
  logic [WIDTH-1:0]   dout_q;
  logic               err_q;

  logic [WIDTH-1:0]   imm_result;
  logic               imm_err;
  logic               is_shift;
  logic               start_shift;
  logic [SHAMT_W-1:0] shamt_in;
  logic               lt_signed;
  logic               lt_unsigned;
  logic               is_eq;

  // sll (f3=1) and srl/sra (f3=5) are the only iterative ops
  assign is_shift    = !op[4] && (op[1:0] == 2'b01);
  assign shamt_in    = b[SHAMT_W-1:0];
  assign start_shift = is_shift && (shamt_in != '0);

  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;
  assign is_eq       = (a == b);

  // One-bit step; right shifts pull in the fill bit latched at accept time
  assign acc_shifted = shift_left ? {acc[WIDTH-2:0], 1'b0} : {fill_bit, acc[WIDTH-1:1]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dout      = dout_q;
  assign err       = err_q;
  assign state_dbg = state;

  // Single-cycle result straight from the inputs; shifts by zero pass a through
  always_comb begin
    imm_result = '0;
    imm_err    = 1'b0;
    if (!op[4]) begin
      case (op[2:0])
        3'd0:    imm_result = op[3] ? (a - b) : (a + b);
        3'd1:    imm_result = a;
        3'd2:    imm_result[0] = lt_signed;
        3'd3:    imm_result[0] = lt_unsigned;
        3'd4:    imm_result = a ^ b;
        3'd5:    imm_result = a;
        3'd6:    imm_result = a | b;
        default: imm_result = a & b;
      endcase
    end else begin
      case (op[2:0])
        3'd0:    imm_result[0] = is_eq;
        3'd1:    imm_result[0] = !is_eq;
        3'd4:    imm_result[0] = lt_signed;
        3'd5:    imm_result[0] = !lt_signed;
        3'd6:    imm_result[0] = lt_unsigned;
        3'd7:    imm_result[0] = !lt_unsigned;
        default: imm_err = 1'b1;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt == SHAMT_W'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: capture at accept, iterate shifts, latch result on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
      fill_bit   <= 1'b0;
      dout_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start_shift) begin
              acc        <= a;
              cnt        <= shamt_in;
              shift_left <= !op[2];
              fill_bit   <= op[2] && op[3] && a[WIDTH-1];
            end else begin
              dout_q <= imm_result;
              err_q  <= imm_err;
            end
          end
        end
        SHIFT: begin
          acc <= acc_shifted;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            dout_q <= acc_shifted;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
